// File: rtl/alu_pkg.sv
// Shared types and constants for the accumulator-CPU ALU.
// Optional divider is controlled by the ALU_DIV_EN macro.
package alu_pkg;

  localparam int ALU_WIDTH = 16;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_NOT = 4'd4,
    OP_SHL = 4'd5,
    OP_SHR = 4'd6,
    OP_MPY = 4'd7,
    OP_DIV = 4'd8
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_DONE = 2'd2
  } alu_state_e;

  // Bit positions inside the {Z,N,C,V} flag word.
  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_if.sv
// ALU request/result bundle. Handshake: i_start is taken only while o_busy=0;
// results and o_illegal are valid only in the single cycle o_done=1, zero otherwise.
interface alu_if #(
  parameter int WIDTH = 16
);
  logic             i_start;
  logic [3:0]       i_op;
  logic [WIDTH-1:0] i_acc_alu_p;
  logic [WIDTH-1:0] i_br_alu_q;
  logic [WIDTH-1:0] o_alu_br;
  logic [WIDTH-1:0] o_alu_mr;
  logic             o_busy;
  logic             o_done;
  logic [3:0]       o_flags;
  logic             o_illegal;

  modport master (
    output i_start, i_op, i_acc_alu_p, i_br_alu_q,
    input  o_alu_br, o_alu_mr, o_busy, o_done, o_flags, o_illegal
  );

  modport slave (
    input  i_start, i_op, i_acc_alu_p, i_br_alu_q,
    output o_alu_br, o_alu_mr, o_busy, o_done, o_flags, o_illegal
  );
endinterface

// File: rtl/alu_iter_muldiv.sv
// Iterative shift-add multiplier and (with ALU_DIV_EN) restoring divider.
// hi/lo form one 2*WIDTH shift register; o_nxt_* is the value after the current step.
module alu_iter_muldiv #(
  parameter int WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic             i_step,
`ifdef ALU_DIV_EN
  input  logic             i_div,
`endif
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_last,
  output logic [WIDTH-1:0] o_nxt_hi,
  output logic [WIDTH-1:0] o_nxt_lo
);
  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, opd_q, opd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   mpy_sum;
`ifdef ALU_DIV_EN
  logic             div_q, div_d;
  logic [WIDTH:0]   div_shift, div_diff;
`endif

  always_comb begin
    mpy_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opd_q} : '0);
    o_nxt_hi = mpy_sum[WIDTH:1];
    o_nxt_lo = {mpy_sum[0], lo_q[WIDTH-1:1]};
`ifdef ALU_DIV_EN
    // Remainder stays below the divisor, so bit WIDTH of the difference is the borrow.
    div_shift = {hi_q, lo_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opd_q};
    if (div_q) begin
      if (!div_diff[WIDTH]) begin
        o_nxt_hi = div_diff[WIDTH-1:0];
        o_nxt_lo = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
        o_nxt_hi = div_shift[WIDTH-1:0];
        o_nxt_lo = {lo_q[WIDTH-2:0], 1'b0};
      end
    end
`endif
  end

  assign o_last = (cnt_q == '0);

  always_comb begin
    hi_d  = hi_q;
    lo_d  = lo_q;
    opd_d = opd_q;
    cnt_d = cnt_q;
`ifdef ALU_DIV_EN
    div_d = div_q;
`endif
    if (i_load) begin
      hi_d  = '0;
      cnt_d = CW'(WIDTH - 1);
      lo_d  = i_b;
      opd_d = i_a;
`ifdef ALU_DIV_EN
      div_d = i_div;
      if (i_div) begin
        lo_d  = i_a;
        opd_d = i_b;
      end
`endif
    end else if (i_step) begin
      hi_d  = o_nxt_hi;
      lo_d  = o_nxt_lo;
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      hi_q  <= '0;
      lo_q  <= '0;
      opd_q <= '0;
      cnt_q <= '0;
`ifdef ALU_DIV_EN
      div_q <= 1'b0;
`endif
    end else begin
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      opd_q <= opd_d;
      cnt_q <= cnt_d;
`ifdef ALU_DIV_EN
      div_q <= div_d;
`endif
    end
  end
endmodule

// File: rtl/alu_core.sv
// ALU top: FSM, single-cycle ops, flags and done-gated outputs.
// Define ALU_DIV_EN to make opcode 8 an iterative unsigned divide.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  alu_if.slave       bus,
  output alu_state_e o_dbg_state
);
  alu_state_e       state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] br_q, br_d, mr_q, mr_d;
  logic [3:0]       flags_q, flags_d;
  logic             ill_q, ill_d;
  logic             load, step, start_iter, it_last;
  logic [WIDTH-1:0] nxt_hi, nxt_lo, sc_br, a, b;
  logic             sc_c, sc_v, sc_ill;
  logic [WIDTH:0]   ext;
`ifdef ALU_DIV_EN
  logic             bzero_q, bzero_d;
  assign start_iter = (bus.i_op == OP_MPY) || (bus.i_op == OP_DIV);
`else
  assign start_iter = (bus.i_op == OP_MPY);
`endif

  assign a = bus.i_acc_alu_p;
  assign b = bus.i_br_alu_q;

  always_comb begin
    sc_br = '0; sc_c = 1'b0; sc_v = 1'b0; sc_ill = 1'b0;
    ext   = '0;
    case (bus.i_op)
      OP_ADD: begin
        ext   = {1'b0, a} + {1'b0, b};
        sc_br = ext[WIDTH-1:0];
        sc_c  = ext[WIDTH];
        sc_v  = (a[WIDTH-1] == b[WIDTH-1]) && (sc_br[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        ext   = {1'b0, a} - {1'b0, b};
        sc_br = ext[WIDTH-1:0];
        sc_c  = ext[WIDTH];
        sc_v  = (a[WIDTH-1] != b[WIDTH-1]) && (sc_br[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: sc_br = a & b;
      OP_OR:  sc_br = a | b;
      OP_NOT: sc_br = ~a;
      OP_SHL: begin sc_br = {a[WIDTH-2:0], 1'b0}; sc_c = a[WIDTH-1]; end
      OP_SHR: begin sc_br = {1'b0, a[WIDTH-1:1]}; sc_c = a[0]; end
      default: sc_ill = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    br_d    = br_q;
    mr_d    = mr_q;
    flags_d = flags_q;
    ill_d   = ill_q;
    load    = 1'b0;
    step    = 1'b0;
`ifdef ALU_DIV_EN
    bzero_d = bzero_q;
`endif
    case (state_q)
      ST_IDLE: if (bus.i_start) begin
        op_d = bus.i_op;
`ifdef ALU_DIV_EN
        bzero_d = (b == '0);
`endif
        if (start_iter) begin
          load    = 1'b1;
          state_d = ST_ITER;
        end else begin
          br_d    = sc_ill ? '0 : sc_br;
          mr_d    = '0;
          ill_d   = sc_ill;
          flags_d = '0;
          if (!sc_ill) begin
            flags_d[FLAG_Z] = (sc_br == '0);
            flags_d[FLAG_N] = sc_br[WIDTH-1];
            flags_d[FLAG_C] = sc_c;
            flags_d[FLAG_V] = sc_v;
          end
          state_d = ST_DONE;
        end
      end
      ST_ITER: begin
        step = 1'b1;
        if (it_last) begin
          br_d            = nxt_lo;
          mr_d            = nxt_hi;
          ill_d           = 1'b0;
          flags_d         = '0;
          flags_d[FLAG_Z] = (nxt_lo == '0) && (nxt_hi == '0);
          flags_d[FLAG_N] = nxt_lo[WIDTH-1];
          if (op_q == OP_MPY) begin
            flags_d[FLAG_C] = (nxt_hi != '0);
            flags_d[FLAG_V] = (nxt_hi != '0);
          end
`ifdef ALU_DIV_EN
          else flags_d[FLAG_V] = bzero_q;
`endif
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      br_q    <= '0;
      mr_q    <= '0;
      flags_q <= '0;
      ill_q   <= 1'b0;
`ifdef ALU_DIV_EN
      bzero_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      br_q    <= br_d;
      mr_q    <= mr_d;
      flags_q <= flags_d;
      ill_q   <= ill_d;
`ifdef ALU_DIV_EN
      bzero_q <= bzero_d;
`endif
    end
  end

  alu_iter_muldiv #(.WIDTH(WIDTH)) u_iter (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_load   (load),
    .i_step   (step),
`ifdef ALU_DIV_EN
    .i_div    (bus.i_op == OP_DIV),
`endif
    .i_a      (a),
    .i_b      (b),
    .o_last   (it_last),
    .o_nxt_hi (nxt_hi),
    .o_nxt_lo (nxt_lo)
  );

  // Zero outside the done cycle: downstream treats a zero word as "no write".
  assign bus.o_done    = (state_q == ST_DONE);
  assign bus.o_busy    = (state_q != ST_IDLE);
  assign bus.o_alu_br  = bus.o_done ? br_q : '0;
  assign bus.o_alu_mr  = bus.o_done ? mr_q : '0;
  assign bus.o_illegal = bus.o_done & ill_q;
  assign bus.o_flags   = flags_q;
  assign o_dbg_state   = state_q;
endmodule

// File: tb/tb_alu_core.sv
// Directed-vector bench for alu_core; DIV vectors depend on ALU_DIV_EN.
module tb_alu_core;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  alu_state_e dbg_state;
  int         n_checks = 0;
  int         n_fail = 0;
  logic [15:0] exp_q[$];

  alu_if #(.WIDTH(16)) bus ();

  alu_core #(.WIDTH(16)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one op, follow it to its done strobe, then check the idle cycle after it.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [15:0] a,
                        input logic [15:0] b, input int exp_lat, input logic [15:0] e_br,
                        input logic [15:0] e_mr, input logic [3:0] e_fl, input logic e_ill,
                        input bit disturb);
    int cyc;
    bit seen;
    logic [15:0] want;
    @(negedge clk);
    bus.i_start = 1'b1; bus.i_op = op; bus.i_acc_alu_p = a; bus.i_br_alu_q = b;
    exp_q.push_back(e_br);
    @(posedge clk);
    #1 bus.i_start = 1'b0;
    if (disturb) begin
      bus.i_acc_alu_p = 16'h5555;
      bus.i_br_alu_q  = 16'h3333;
    end
    cyc = 0;
    seen = 1'b0;
    while (!seen && cyc < 40) begin
      @(negedge clk);
      cyc++;
      check({tag, "_busy"}, 64'(bus.o_busy), 64'd1);
      if (bus.o_done) seen = 1'b1;
      else begin
        check({tag, "_gate"}, {31'd0, bus.o_alu_br, bus.o_alu_mr, bus.o_illegal}, 64'd0);
        if (disturb && cyc == 5) begin bus.i_start = 1'b1; bus.i_op = OP_ADD; end
        if (disturb && cyc == 6) bus.i_start = 1'b0;
      end
    end
    check({tag, "_done_seen"}, 64'(seen), 64'd1);
    want = exp_q.pop_front();
    if (seen) begin
      check({tag, "_lat"}, 64'(cyc), 64'(exp_lat));
      check({tag, "_br"}, 64'(bus.o_alu_br), 64'(want));
      check({tag, "_mr"}, 64'(bus.o_alu_mr), 64'(e_mr));
      check({tag, "_flags"}, 64'(bus.o_flags), 64'(e_fl));
      check({tag, "_illegal"}, 64'(bus.o_illegal), 64'(e_ill));
      if (disturb) begin bus.i_start = 1'b1; bus.i_op = OP_ADD; end
    end
    @(negedge clk);
    bus.i_start = 1'b0;
    check({tag, "_post_busy_done"}, {62'd0, bus.o_busy, bus.o_done}, 64'd0);
    check({tag, "_post_br"}, 64'(bus.o_alu_br), 64'd0);
    check({tag, "_post_flags_held"}, 64'(bus.o_flags), 64'(e_fl));
  endtask

  initial begin
    bus.i_start = 1'b0; bus.i_op = '0; bus.i_acc_alu_p = '0; bus.i_br_alu_q = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("rst_outputs", {bus.o_alu_br, bus.o_alu_mr, 20'd0, bus.o_flags,
                          bus.o_busy, bus.o_done, bus.o_illegal, 1'b0}, 64'd0);
    check("rst_state", 64'(dbg_state), 64'(ST_IDLE));

    run_op("add_ovf",  OP_ADD, 16'h7FFF, 16'h0001, 1, 16'h8000, 16'h0000, 4'h5, 1'b0, 1'b0);
    run_op("sub_brw",  OP_SUB, 16'h0003, 16'h0005, 1, 16'hFFFE, 16'h0000, 4'h6, 1'b0, 1'b0);
    run_op("add_wrap", OP_ADD, 16'hFFFF, 16'h0001, 1, 16'h0000, 16'h0000, 4'hA, 1'b0, 1'b0);
    run_op("sub_ovf",  OP_SUB, 16'h8000, 16'h0001, 1, 16'h7FFF, 16'h0000, 4'h1, 1'b0, 1'b0);
    run_op("and_zero", OP_AND, 16'h00F0, 16'h0F00, 1, 16'h0000, 16'h0000, 4'h8, 1'b0, 1'b0);
    run_op("or",       OP_OR,  16'h1200, 16'h0034, 1, 16'h1234, 16'h0000, 4'h0, 1'b0, 1'b0);
    run_op("not",      OP_NOT, 16'h00FF, 16'h1111, 1, 16'hFF00, 16'h0000, 4'h4, 1'b0, 1'b0);
    run_op("shl",      OP_SHL, 16'h8001, 16'h0000, 1, 16'h0002, 16'h0000, 4'h2, 1'b0, 1'b0);
    run_op("shr",      OP_SHR, 16'h0003, 16'h0000, 1, 16'h0001, 16'h0000, 4'h2, 1'b0, 1'b0);
    run_op("ill_12",   4'd12,  16'h1234, 16'h5678, 1, 16'h0000, 16'h0000, 4'h0, 1'b1, 1'b0);
    run_op("mpy_a",    OP_MPY, 16'h1234, 16'h0100, 17, 16'h3400, 16'h0012, 4'h3, 1'b0, 1'b0);
    run_op("mpy_max",  OP_MPY, 16'hFFFF, 16'hFFFF, 17, 16'h0001, 16'hFFFE, 4'h3, 1'b0, 1'b0);
    run_op("mpy_ign",  OP_MPY, 16'h0003, 16'h0005, 17, 16'h000F, 16'h0000, 4'h0, 1'b0, 1'b1);

    // Reset during cycle 8 of a multiply; flags from mpy_max-like op must clear.
    run_op("mpy_pre",  OP_MPY, 16'h00FF, 16'h0100, 17, 16'hFF00, 16'h0000, 4'h4, 1'b0, 1'b0);
    @(negedge clk);
    bus.i_start = 1'b1; bus.i_op = OP_MPY; bus.i_acc_alu_p = 16'h1234; bus.i_br_alu_q = 16'h0100;
    @(posedge clk);
    #1 bus.i_start = 1'b0;
    repeat (8) @(negedge clk);
    check("rst_mid_busy", 64'(bus.o_busy), 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_mid_outputs", {bus.o_alu_br, bus.o_alu_mr, 20'd0, bus.o_flags,
                              bus.o_busy, bus.o_done, bus.o_illegal, 1'b0}, 64'd0);
    check("rst_mid_state", 64'(dbg_state), 64'(ST_IDLE));
    rst_n = 1'b1;
    run_op("add_2p2",  OP_ADD, 16'h0002, 16'h0002, 1, 16'h0004, 16'h0000, 4'h0, 1'b0, 1'b0);

`ifdef ALU_DIV_EN
    run_op("div_100_7", OP_DIV, 16'd100, 16'd7, 17, 16'd14, 16'd2, 4'h0, 1'b0, 1'b0);
    run_op("div_by0",   OP_DIV, 16'd5, 16'd0, 17, 16'hFFFF, 16'd5, 4'h5, 1'b0, 1'b0);
`else
    run_op("div_ill",   OP_DIV, 16'd100, 16'd7, 1, 16'h0000, 16'h0000, 4'h0, 1'b1, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_core.md
# alu_core

Arithmetic/logic unit for the accumulator CPU, directly upstream of the ACC register: it consumes the ACC operand (ALU P-side) and the BR/MBR operand (Q-side) and produces the low result word for BR→ACC and the high product or remainder word for MR→ACC. Logic ops complete in one cycle. MPY, and optionally DIV, run as 16-step iterative operations behind a start/busy/done handshake. Result ports are zero except in the done cycle, which matches the downstream convention that a zero word means "no write".

## Interface
- `WIDTH`, 16, operand/result width; the iteration count equals `WIDTH`.
- `i_clk`, in, 1, clock; all state changes on the rising edge.
- `i_rst_n`, in, 1, reset; one clock, synchronous, active-low.
- `i_start`, in, 1, operation request; sampled only in IDLE.
- `i_op`, in, 4, opcode, captured with `i_start`.
- `i_acc_alu_p`, in, WIDTH, operand A (ACC).
- `i_br_alu_q`, in, WIDTH, operand B (BR/MBR).
- `o_alu_br`, out, WIDTH, low result; non-zero only while `o_done`.
- `o_alu_mr`, out, WIDTH, product high half or remainder; non-zero only while `o_done`.
- `o_busy`, out, 1, high whenever state ≠ IDLE.
- `o_done`, out, 1, one-cycle result strobe.
- `o_flags`, out, 4, {Z,N,C,V}; registered, held between done strobes.
- `o_illegal`, out, 1, pulses together with `o_done` for an undefined opcode.

## Operation
- Opcodes:
  - 0 ADD, 1 SUB (A−B), 2 AND, 3 OR, 4 NOT A.
  - 5 SHL A by 1, 6 SHR A by 1 (logical).
  - 7 MPY (unsigned A×B, 2·WIDTH-bit result).
  - 8 DIV (A÷B, unsigned; configurable, see Configuration).
  - 9–15 illegal.
- Operand capture: on an IDLE cycle with `i_start`=1, A, B and op are latched. Later input changes have no effect.
- FSM:
  - IDLE→DONE for single-cycle ops and for illegal opcodes.
  - IDLE→ITER for MPY/DIV. ITER lasts exactly WIDTH cycles under a down-counter (WIDTH−1..0), then goes to DONE.
  - DONE→IDLE unconditionally after one cycle.
- `i_start` in ITER or DONE is ignored; it is not queued.
- MPY: shift-add, one multiplier bit per cycle. BR = product[WIDTH−1:0], MR = product[2·WIDTH−1:WIDTH].
- Flags, updated only at DONE:
  - Z: BR result is zero (MPY/DIV: both halves zero).
  - N: MSB of BR.
  - C: carry out (ADD); borrow, i.e. A<B unsigned (SUB); shifted-out bit (SHL/SHR); MR≠0 (MPY); 0 for all other ops.
  - V: signed overflow (ADD/SUB); MR≠0 (MPY); divide-by-zero (DIV); 0 for all other ops.
- Illegal opcode: BR=MR=0, flags cleared to 0000, `o_illegal`=1 for the done cycle.
- Reset mid-operation: state goes to IDLE, counter and partial product/remainder registers clear, all outputs 0 on the next edge.

## Timing
- Reset values: `o_alu_br`, `o_alu_mr`, `o_flags` = 0; `o_busy`, `o_done`, `o_illegal` = 0.
- Start sampled at edge 0:
  - Single-cycle op: `o_done` high in cycle 1, `o_busy` high in cycle 1.
  - MPY/DIV: ITER in cycles 1..WIDTH, `o_done` in cycle WIDTH+1 (cycle 17 for WIDTH=16).
- Earliest next accepted start: the cycle after DONE (back-to-back single-cycle ops give a throughput of 1 op per 2 cycles).
- A result of zero still strobes `o_done`; the downstream stage relies on Z, not on the data, to detect it.

## Configuration
- `ALU_DIV_EN` defined:
  - Opcode 8 runs restoring division over WIDTH cycles. BR = quotient, MR = remainder.
  - B=0 gives BR=all ones, MR=A, V=1.
  - The DIV datapath shares the shift register and counter with MPY.
- `ALU_DIV_EN` undefined: opcode 8 is illegal (latency 1, zero results, `o_illegal`), and no divider logic is synthesized.

## Structure
- Shared package `alu_pkg` holds:
  - opcode enumeration;
  - FSM state enumeration (IDLE, ITER, DONE);
  - flag bit-index constants;
  - default WIDTH.
- One sub-module, `alu_iter_muldiv`, contains the iterative MPY/DIV datapath: accumulator/remainder register, shift register and step counter, with load/step/finish controls. The top level holds the FSM, the single-cycle ops, the flags and output gating.

## Test plan
- ADD A=0x7FFF, B=0x0001 → done at cycle 1; BR=0x8000, flags N=1, V=1, C=0, Z=0. SUB 0x0003−0x0005 → BR=0xFFFE, C=1, N=1.
- MPY 0x1234×0x0100 → done exactly at cycle 17, busy cycles 1–17; BR=0x3400, MR=0x0012, C=V=1. MPY 0xFFFF×0xFFFF → BR=0x0001, MR=0xFFFE.
- `i_start` pulses with changed operands during ITER and during the DONE cycle → ignored; the result matches the first operands. Only one `o_done` pulse.
- Reset asserted at cycle 8 of an MPY → all outputs 0 on the next edge. A fresh ADD 2+2 then gives BR=0x0004 at latency 1.
- DIV 100÷7 → BR=14, MR=2 at cycle 17. DIV 5÷0 → BR=0xFFFF, MR=5, V=1. With `ALU_DIV_EN` undefined: opcode 8 → `o_illegal`=1 at cycle 1, BR=MR=0.
- AND 0x00F0&0x0F00 → BR=0x0000, Z=1, `o_done`=1. The outputs read zero in every non-done cycle.
